// File: rtl/fft_axi_master.sv
// Initiator side of the FFT AXI bridge: streams N samples into the write channel, waits for
// the FFT core, then drains N results through a 2-entry buffer into the local sink.
module fft_axi_master #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RES_W   = 32,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_samples_number,
    input  logic [DATA_W-1:0] i_src_data,
    input  logic              i_src_valid,
    output logic              o_src_ready,
    output logic [DATA_W-1:0] o_AWDATA,
    output logic              o_AWVALID,
    input  logic              i_AWREADY,
    input  logic [1:0]        i_AWBURST,
    input  logic              i_CALC_END,
    input  logic [RES_W-1:0]  i_ARDATA,
    input  logic              i_ARVALID,
    output logic              o_ARREADY,
    input  logic [1:0]        i_ARBURST,
    output logic [CNT_W-1:0]  o_SAMPLES_NUMBER,
    output logic [RES_W-1:0]  o_res_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_CALC,
        READ,
        DONE,
        ERROR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W:0]     fetch_q;
    logic [CNT_W:0]     wr_q;
    logic [CNT_W:0]     rd_q;
    logic [CNT_W:0]     out_q;
    logic [31:0]        tmo_q;
    logic               aw_valid_q;
    logic [DATA_W-1:0]  aw_data_q;
    logic               ar_ready_q;
    logic               done_q;
    logic               error_q;
    logic [RES_W-1:0]   fifo_q [2];
    logic               wptr_q;
    logic               rptr_q;
    logic [1:0]         count_q;

    logic [CNT_W:0]     n_ext;
    logic               aw_err;
    logic               ar_err;
    logic               src_ready;
    logic               src_fire;
    logic               aw_fire;
    logic               res_valid;
    logic               push;
    logic               pop;
    logic [1:0]         count_d;
    logic [CNT_W:0]     rd_d;
    logic               ar_ready_d;

    // Counters are one bit wider than N so a full-scale block ends without wrapping.
    always_comb begin
        n_ext     = {1'b0, n_q};
        aw_err    = (state_q == WRITE) && (i_AWBURST == 2'b11);
        ar_err    = (state_q == READ) && (i_ARBURST == 2'b11);
        src_ready = (state_q == WRITE) && !aw_err && (!aw_valid_q || i_AWREADY) && (fetch_q < n_ext);
        src_fire  = src_ready && i_src_valid;
        aw_fire   = (state_q == WRITE) && aw_valid_q && i_AWREADY;
        res_valid = (count_q != 2'd0);
        push      = (state_q == READ) && !ar_err && ar_ready_q && i_ARVALID;
        pop       = (state_q == READ) && !ar_err && res_valid && i_res_ready;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        rd_d       = push ? (rd_q + 1'b1) : rd_q;
        ar_ready_d = (count_d != 2'd2) && (rd_d < n_ext);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            fetch_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            out_q      <= '0;
            tmo_q      <= '0;
            aw_valid_q <= 1'b0;
            aw_data_q  <= '0;
            ar_ready_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_samples_number != '0) begin
                            n_q     <= i_samples_number;
                            error_q <= 1'b0;
                            fetch_q <= '0;
                            wr_q    <= '0;
                            rd_q    <= '0;
                            out_q   <= '0;
                            tmo_q   <= '0;
                            state_q <= WRITE;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (aw_err) begin
                        aw_valid_q <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= ERROR;
                    end else begin
                        if (src_fire) begin
                            aw_data_q  <= i_src_data;
                            aw_valid_q <= 1'b1;
                            fetch_q    <= fetch_q + 1'b1;
                        end else if (aw_fire) begin
                            aw_valid_q <= 1'b0;
                        end
                        if (aw_fire) begin
                            wr_q <= wr_q + 1'b1;
                            if ((wr_q + 1'b1) == n_ext) begin
                                tmo_q   <= '0;
                                state_q <= WAIT_CALC;
                            end
                        end
                    end
                end
                WAIT_CALC: begin
                    if (i_CALC_END) begin
                        ar_ready_q <= 1'b1;
                        state_q    <= READ;
                    end else if ((TIMEOUT != 0) && (tmo_q == TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                READ: begin
                    if (ar_err) begin
                        ar_ready_q <= 1'b0;
                        count_q    <= 2'd0;
                        wptr_q     <= 1'b0;
                        rptr_q     <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= ERROR;
                    end else begin
                        if (push) begin
                            fifo_q[wptr_q] <= i_ARDATA;
                            wptr_q         <= ~wptr_q;
                        end
                        if (pop) begin
                            rptr_q <= ~rptr_q;
                            out_q  <= out_q + 1'b1;
                        end
                        count_q    <= count_d;
                        rd_q       <= rd_d;
                        ar_ready_q <= ar_ready_d;
                        // The last delivered result also empties the buffer.
                        if (pop && ((out_q + 1'b1) == n_ext)) begin
                            ar_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                ERROR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_src_ready      = src_ready;
    assign o_AWDATA         = aw_data_q;
    assign o_AWVALID        = aw_valid_q;
    assign o_ARREADY        = ar_ready_q;
    assign o_SAMPLES_NUMBER = n_q;
    assign o_res_data       = fifo_q[rptr_q];
    assign o_res_valid      = res_valid;
    assign o_busy           = (state_q != IDLE);
    assign o_done           = done_q;
    assign o_error          = error_q;

endmodule

// File: tb/tb_fft_axi_master.sv
// Directed bench for fft_axi_master: acts as source, bridge and sink, driven by a vector table.
module tb_fft_axi_master;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [11:0] i_samples_number = '0;
    logic [15:0] i_src_data = '0;
    logic        i_src_valid = 1'b0;
    logic        o_src_ready;
    logic [15:0] o_AWDATA;
    logic        o_AWVALID;
    logic        i_AWREADY = 1'b0;
    logic [1:0]  i_AWBURST = 2'b00;
    logic        i_CALC_END = 1'b0;
    logic [31:0] i_ARDATA = '0;
    logic        i_ARVALID = 1'b0;
    logic        o_ARREADY;
    logic [1:0]  i_ARBURST = 2'b00;
    logic [11:0] o_SAMPLES_NUMBER;
    logic [31:0] o_res_data;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int testsRun = 0;
    int testsFailed = 0;

    fft_axi_master #(
        .DATA_W(16), .RES_W(32), .CNT_W(12), .TIMEOUT(20)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_samples_number(i_samples_number),
        .i_src_data(i_src_data), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .o_AWDATA(o_AWDATA), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY), .i_AWBURST(i_AWBURST),
        .i_CALC_END(i_CALC_END), .i_ARDATA(i_ARDATA), .i_ARVALID(i_ARVALID), .o_ARREADY(o_ARREADY),
        .i_ARBURST(i_ARBURST), .o_SAMPLES_NUMBER(o_SAMPLES_NUMBER), .o_res_data(o_res_data),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int n;
        bit awToggle;
        int sinkStall;
        int calcDelay;
        int arErrAfter;
        int rstAfter;
        bit pokeStart;
        int expDone;
        int expError;
        int expWrites;
        int expResults;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [11:0] n);
        i_start          = start;
        i_samples_number = n;
    endtask

    task automatic idleInputs();
        i_start     = 1'b0;
        i_src_valid = 1'b0;
        i_AWREADY   = 1'b0;
        i_AWBURST   = 2'b00;
        i_CALC_END  = 1'b0;
        i_ARVALID   = 1'b0;
        i_ARBURST   = 2'b00;
        i_res_ready = 1'b0;
    endtask

    task automatic runBlock(input vec_t v);
        int srcIdx = 0, awCnt = 0, arCnt = 0, sinkCnt = 0, doneCnt = 0;
        int waitCyc = 0, stallCnt = 0, errIter = -1;
        bit writesDone = 0, calcSent = 0, arCheck = 0, doneCheck = 0, errInjected = 0;
        bit rstPending = 0, finished = 0, timeoutChecked = 0, prevStall = 0;
        logic [15:0] prevData = '0;
        @(negedge i_clk);
        applyStimulus(1'b1, 12'(v.n));
        @(negedge i_clk);
        applyStimulus(1'b0, 12'(v.n));
        checkOutput("start_busy", 32'(o_busy), 32'd1);
        checkOutput("start_error_clear", 32'(o_error), 32'd0);
        checkOutput("start_samples_number", 32'(o_SAMPLES_NUMBER), 32'(v.n));
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (cyc != 0) @(negedge i_clk);
            if (writesDone) waitCyc++;
            i_start = 1'b0;
            if (v.pokeStart && !calcSent) applyStimulus(1'b1, 12'h7FF);
            i_src_valid = 1'b1;
            i_src_data  = 16'(srcIdx + 1);
            i_AWREADY   = v.awToggle ? (cyc % 2 == 0) : 1'b1;
            i_CALC_END  = writesDone && !calcSent && (v.calcDelay >= 0) && (waitCyc == v.calcDelay);
            i_ARVALID   = calcSent && (arCnt < v.n);
            i_ARDATA    = 32'hC0DE_0000 + 32'(arCnt);
            i_ARBURST   = 2'b00;
            i_res_ready = !(calcSent && (stallCnt < v.sinkStall));
            if (calcSent) stallCnt++;
            if (v.arErrAfter >= 0 && !errInjected && calcSent && arCnt == v.arErrAfter) begin
                i_ARBURST   = 2'b11;
                i_ARVALID   = 1'b0;
                i_res_ready = 1'b0;
                errInjected = 1;
                errIter     = cyc;
            end
            if (rstPending) begin
                i_rst = 1'b0;
                #1;
                checkOutput("rst_busy_done_error", 32'({o_busy, o_done, o_error}), 32'd0);
                checkOutput("rst_valids_readys", 32'({o_src_ready, o_AWVALID, o_ARREADY, o_res_valid}), 32'd0);
                checkOutput("rst_awdata", 32'(o_AWDATA), 32'd0);
                checkOutput("rst_res_data", o_res_data, 32'd0);
                finished = 1;
            end else if (v.rstAfter >= 0 && awCnt == v.rstAfter) begin
                i_rst      = 1'b1;
                rstPending = 1;
            end else begin
                #1;
                if (arCheck) begin
                    checkOutput("calc_end_to_arready", 32'(o_ARREADY), 32'd1);
                    arCheck = 0;
                end
                if (doneCheck) begin
                    checkOutput("done_after_last_result", 32'(o_done), 32'd1);
                    doneCheck = 0;
                end
                if (o_done) doneCnt++;
                if (errIter >= 0 && cyc == errIter + 1) begin
                    checkOutput("arburst_err_error", 32'(o_error), 32'd1);
                    checkOutput("arburst_err_outputs", 32'({o_ARREADY, o_res_valid, o_src_ready, o_AWVALID}), 32'd0);
                end
                if (writesDone && !timeoutChecked && v.calcDelay < 0 && o_error) begin
                    checkOutput("timeout_cycles", 32'(waitCyc), 32'd21);
                    timeoutChecked = 1;
                end
                if (prevStall) checkOutput("awdata_hold", 32'(o_AWDATA), 32'(prevData));
                prevStall = o_AWVALID && !i_AWREADY;
                prevData  = o_AWDATA;
                if (arCnt - sinkCnt == 2) checkOutput("arready_full", 32'(o_ARREADY), 32'd0);
                if (o_AWVALID && i_AWREADY) begin
                    checkOutput("awdata", 32'(o_AWDATA), 32'(awCnt + 1));
                    awCnt++;
                    if (awCnt == v.n) begin
                        writesDone = 1;
                        waitCyc    = 0;
                    end
                end
                if (i_src_valid && o_src_ready) srcIdx++;
                if (i_ARVALID && o_ARREADY) arCnt++;
                if (o_res_valid && i_res_ready) begin
                    checkOutput("res_data", o_res_data, 32'hC0DE_0000 + 32'(sinkCnt));
                    sinkCnt++;
                    if (sinkCnt == v.n) doneCheck = 1;
                end
                if (i_CALC_END) begin
                    calcSent = 1;
                    arCheck  = 1;
                end
                if (cyc > 0 && !o_busy) finished = 1;
            end
        end
        idleInputs();
        checkOutput("block_finished", 32'(finished), 32'd1);
        checkOutput("done_count", 32'(doneCnt), 32'(v.expDone));
        checkOutput("error_flag", 32'(o_error), 32'(v.expError));
        checkOutput("write_beats", 32'(awCnt), 32'(v.expWrites));
        if (v.expResults >= 0) checkOutput("results_delivered", 32'(sinkCnt), 32'(v.expResults));
        checkOutput("end_samples_number", 32'(o_SAMPLES_NUMBER), (v.rstAfter >= 0) ? 32'd0 : 32'(v.n));
    endtask

    initial begin
        //           n  tog stall calc arErr rst poke done err  wr  res
        vecs[0] = '{ 2, 0,  0,    10,  -1,  -1, 0,   1,   0,   2,  2};
        vecs[1] = '{ 4, 0,  0,    10,  -1,  -1, 0,   1,   0,   4,  4};
        vecs[2] = '{ 8, 1,  5,    10,  -1,  -1, 1,   1,   0,   8,  8};
        vecs[3] = '{ 3, 0,  0,    -1,  -1,  -1, 0,   0,   1,   3,  0};
        vecs[4] = '{ 8, 0,  0,    10,   3,  -1, 0,   0,   1,   8, -1};
        vecs[5] = '{16, 0,  0,    10,  -1,   5, 0,   0,   0,   5,  0};
        vecs[6] = '{16, 0,  0,    10,  -1,  -1, 0,   1,   0,  16, 16};

        idleInputs();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_busy_done_error", 32'({o_busy, o_done, o_error}), 32'd0);
        checkOutput("reset_valids_readys", 32'({o_src_ready, o_AWVALID, o_ARREADY, o_res_valid}), 32'd0);
        checkOutput("reset_samples_number", 32'(o_SAMPLES_NUMBER), 32'd0);
        i_rst = 1'b0;

        // A zero-length request is refused with a sticky error and no state change.
        @(negedge i_clk);
        applyStimulus(1'b1, 12'd0);
        @(negedge i_clk);
        applyStimulus(1'b0, 12'd0);
        checkOutput("zero_n_error", 32'(o_error), 32'd1);
        checkOutput("zero_n_busy", 32'(o_busy), 32'd0);
        checkOutput("zero_n_samples_number", 32'(o_SAMPLES_NUMBER), 32'd0);
        @(negedge i_clk);
        checkOutput("zero_n_error_sticky", 32'({o_busy, o_error}), 32'd1);

        for (int i = 0; i < 7; i++) begin
            runBlock(vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
